// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, frame geometry, payload type and
// frame/parity helpers used by the device- and host-side models.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        SEND,
        INHIBIT,
        GAP
    } ps2_state_t;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_IDX_W  = 4;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } tx_entry_t;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Frame in wire order from bit 0: start, data LSB first, parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data, input logic perr);
        return {1'b1, odd_parity(data) ^ perr, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous FIFO with occupancy count; head entry is visible combinationally.
module ps2_byte_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head_c,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr  = wr_en && (count != CW'(DEPTH));
    assign do_rd  = rd_en && (count != '0);
    assign head_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_dev_tx_queue.sv
// PS/2 device-side transmitter: queues scan codes and serialises them as
// 11-bit open-drain frames, backing off and retrying when the host inhibits.
module ps2_dev_tx_queue
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HALF   = 4,
    parameter int unsigned GAP_CYC    = 8,
    parameter int unsigned HOLDOFF    = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [7:0]    wr_data,
    input  logic          wr_perr,
    inout  wire           ps2_clk,
    inout  wire           ps2_dat,
    output logic          busy,
    output logic          byte_sent,
    output logic          byte_aborted,
    output logic [CW-1:0] fifo_count
);

    localparam int unsigned PERIOD = 2 * CLK_HALF;
    localparam int unsigned PW     = $clog2(PERIOD);
    localparam int unsigned HW     = $clog2(HOLDOFF + 1);
    localparam int unsigned GW     = $clog2(GAP_CYC + 1);

    ps2_state_t              state, state_n;
    logic [PW-1:0]           phase, phase_n;
    logic [BIT_IDX_W-1:0]    bit_idx, bit_n;
    logic [HW-1:0]           hold_cnt, hold_n;
    logic [GW-1:0]           gap_cnt, gap_n;
    logic                    clk_low, clk_low_n;
    logic                    dat_low, dat_low_n;
    logic                    sent_n, aborted_n, busy_n, ready_n;
    logic [CW-1:0]           count_n;
    tx_entry_t               head;
    logic [FRAME_BITS-1:0]   frame;
    logic                    line_clk, line_dat, bus_high;
    logic                    wr_fire, pop, frame_end, inhibit;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk  = clk_low ? 1'b0 : 1'bz;
    assign ps2_dat  = dat_low ? 1'b0 : 1'bz;
    assign line_clk = ps2_clk;
    assign line_dat = ps2_dat;
    assign bus_high = line_clk && line_dat;

    assign wr_fire = wr_valid && wr_ready;
    assign pop     = byte_sent && (fifo_count != '0);
    assign count_n = fifo_count + CW'(wr_fire) - CW'(pop);

    ps2_byte_fifo #(
        .WIDTH ($bits(tx_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire),
        .wr_data ({wr_perr, wr_data}),
        .rd_en   (byte_sent),
        .head_c  (head),
        .count   (fifo_count)
    );

    assign frame     = build_frame(head.data, head.perr);
    assign frame_end = (state == SEND) && (phase == PW'(PERIOD - 1))
                       && (bit_idx == BIT_IDX_W'(FRAME_BITS - 1));
    // Host may only abort while our clock is released, and never during the stop bit.
    assign inhibit   = (state == SEND) && (phase < PW'(CLK_HALF)) && !line_clk
                       && (bit_idx < BIT_IDX_W'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (fifo_count != '0) state_n = WAIT_BUS;
            WAIT_BUS: if (bus_high && (hold_cnt == HW'(HOLDOFF - 1))) state_n = SEND;
            SEND: begin
                if (inhibit)        state_n = INHIBIT;
                else if (frame_end) state_n = GAP;
            end
            INHIBIT:  if (line_clk) state_n = WAIT_BUS;
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) state_n = (count_n != '0) ? WAIT_BUS : IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        phase_n   = phase;
        bit_n     = bit_idx;
        hold_n    = '0;
        gap_n     = '0;
        sent_n    = 1'b0;
        aborted_n = 1'b0;
        case (state)
            WAIT_BUS: begin
                hold_n  = bus_high ? hold_cnt + HW'(1) : '0;
                phase_n = '0;
                bit_n   = '0;
            end
            SEND: begin
                if (inhibit)                        aborted_n = 1'b1;
                else if (frame_end)                 sent_n    = 1'b1;
                else if (phase == PW'(PERIOD - 1)) begin
                    phase_n = '0;
                    bit_n   = bit_idx + BIT_IDX_W'(1);
                end else                            phase_n   = phase + PW'(1);
            end
            GAP:     gap_n = gap_cnt + GW'(1);
            default: ;
        endcase
        // Line drives are registered from the upcoming phase so they change on clean edges.
        clk_low_n = (state_n == SEND) && (phase_n >= PW'(CLK_HALF));
        dat_low_n = 1'b0;
        if (state_n == SEND)
            dat_low_n = (phase_n == PW'(CLK_HALF / 2)) ? ~frame[bit_n] : dat_low;
        busy_n  = (state_n != IDLE) || (count_n != '0);
        ready_n = (count_n != CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= '0;
            bit_idx      <= '0;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            clk_low      <= 1'b0;
            dat_low      <= 1'b0;
            byte_sent    <= 1'b0;
            byte_aborted <= 1'b0;
            busy         <= 1'b0;
            wr_ready     <= 1'b1;
        end else begin
            phase        <= phase_n;
            bit_idx      <= bit_n;
            hold_cnt     <= hold_n;
            gap_cnt      <= gap_n;
            clk_low      <= clk_low_n;
            dat_low      <= dat_low_n;
            byte_sent    <= sent_n;
            byte_aborted <= aborted_n;
            busy         <= busy_n;
            wr_ready     <= ready_n;
        end
    end

endmodule

// File: tb/tb_ps2_dev_tx_queue.sv
// Bench for ps2_dev_tx_queue: host-side sampler and scoreboard against an
// expected-byte queue, with directed and random stimulus.
module tb_ps2_dev_tx_queue;

    localparam int unsigned CLK_HALF   = 4;
    localparam int unsigned GAP_CYC    = 8;
    localparam int unsigned HOLDOFF    = 8;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
    localparam int          SPACING    = 22 * CLK_HALF + GAP_CYC + HOLDOFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          wr_perr = 1'b0;
    logic          wr_ready, busy, byte_sent, byte_aborted;
    logic [CW-1:0] fifo_count;
    wire           ps2_clk;
    wire           ps2_dat;
    logic          host_clk_low = 1'b0;

    assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;

    ps2_dev_tx_queue #(
        .CLK_HALF   (CLK_HALF),
        .GAP_CYC    (GAP_CYC),
        .HOLDOFF    (HOLDOFF),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_perr      (wr_perr),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .busy         (busy),
        .byte_sent    (byte_sent),
        .byte_aborted (byte_aborted),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pushed = 0;
    int          sent_count = 0;
    int          abort_count = 0;
    int          nbits = 0;
    int          sent_time[$];
    logic [10:0] cur_bits = '0;
    logic [10:0] rx_q[$];
    int          rx_len_q[$];
    logic [8:0]  exp_q[$];
    logic        prev_ps2_clk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Host view: sample data on device-made falling clock edges, frame on byte_sent.
    always @(negedge clk) begin
        if (reset) begin
            nbits = 0;
        end else begin
            if (prev_ps2_clk === 1'b1 && ps2_clk === 1'b0 && !host_clk_low) begin
                if (nbits < 11) cur_bits[nbits] = ps2_dat;
                nbits++;
            end
            if (byte_sent) begin
                sent_count++;
                sent_time.push_back(cyc);
                rx_q.push_back(cur_bits);
                rx_len_q.push_back(nbits);
                nbits = 0;
            end
            if (byte_aborted) begin
                abort_count++;
                nbits = 0;
            end
        end
        prev_ps2_clk = ps2_clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input logic p);
        logic exp_ready;
        exp_ready = (pushed - sent_count) < FIFO_DEPTH;
        check("wr_ready", wr_ready, exp_ready);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_perr  = p;
        if (exp_ready) begin
            exp_q.push_back({p, d});
            pushed++;
        end
        step(1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_sent(input string tag, input int budget);
        int start;
        int k;
        start = sent_count;
        k = 0;
        while (sent_count == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, sent_count > start, 1'b1);
    endtask

    task automatic wait_bits(input string tag, input int n);
        int k;
        k = 0;
        while (nbits != n && k < 3000) begin
            step(1);
            k++;
        end
        check(tag, nbits, n);
        k = 0;
        while (ps2_clk !== 1'b1 && k < 100) begin
            step(1);
            k++;
        end
        check({tag, "_clkhi"}, ps2_clk, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 5000) begin
            step(1);
            k++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        logic [10:0] got;
        logic [10:0] want;
        logic [8:0]  e;
        int          len;
        check({tag, "_avail"}, (rx_q.size() > 0) && (exp_q.size() > 0), 1'b1);
        if (rx_q.size() == 0 || exp_q.size() == 0) return;
        got = rx_q.pop_front();
        len = rx_len_q.pop_front();
        e   = exp_q.pop_front();
        want[0] = 1'b0;
        for (int i = 0; i < 8; i++) want[i+1] = e[i];
        want[9]  = (($countones(e[7:0]) % 2) == 0) ^ e[8];
        want[10] = 1'b1;
        check({tag, "_len"}, len, 11);
        check({tag, "_bits"}, got, want);
    endtask

    task automatic check_spacing(input string tag);
        int n;
        n = sent_time.size();
        check({tag, "_have2"}, n >= 2, 1'b1);
        if (n >= 2) check(tag, sent_time[n-1] - sent_time[n-2], SPACING);
    endtask

    initial begin
        int          s0;
        int          a0;
        int          k;
        logic [10:0] got;
        logic [10:0] want_1c;

        step(3);
        reset = 1'b0;
        check("rst_ps2_clk", ps2_clk, 1'b1);
        check("rst_ps2_dat", ps2_dat, 1'b1);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_sent", byte_sent, 1'b0);
        check("rst_aborted", byte_aborted, 1'b0);
        check("rst_count", fifo_count, 0);

        // Single byte 0x1C: samples 0,0,0,1,1,1,0,0,0,0,1 (bit0 first).
        write_byte(8'h1C, 1'b0);
        wait_sent("single_sent", 400);
        check("single_busy_at_sent", busy, 1'b1);
        want_1c = 11'b100_0011_1000;
        got = rx_q[rx_q.size()-1];
        check("single_samples", got, want_1c);
        check_frame("single");
        @(negedge clk);
        check("single_count0", fifo_count, 0);
        repeat (GAP_CYC - 1) @(negedge clk);
        check("single_busy_drop", busy, 1'b0);
        check("single_no_abort", abort_count, 0);
        step(1);

        // Parity injection on two identical bytes.
        write_byte(8'hF0, 1'b0);
        write_byte(8'hF0, 1'b1);
        wait_sent("par0_sent", 400);
        check("par0_bit", rx_q[rx_q.size()-1][9], 1'b1);
        check_frame("par0");
        wait_sent("par1_sent", 400);
        check("par1_bit", rx_q[rx_q.size()-1][9], 1'b0);
        check_frame("par1");
        check_spacing("par_spacing");
        step(1);
        wait_idle("par_idle");

        // Fill the queue: ninth byte refused.
        for (int i = 1; i <= 9; i++) write_byte(8'(i), 1'b0);
        check("full_count", fifo_count, FIFO_DEPTH);
        check("full_ready", wr_ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wait_sent("full_sent", 400);
            check_frame("full");
            if (i > 0) check_spacing("full_spacing");
        end
        step(1);
        wait_idle("full_idle");
        check("full_drained", fifo_count, 0);

        // Host inhibit during bit 4, then retry of the same byte.
        write_byte(8'h5A, 1'b0);
        wait_bits("inh_bit4", 4);
        s0 = sent_count;
        a0 = abort_count;
        host_clk_low = 1'b1;
        step(200);
        check("inh_abort_once", abort_count, a0 + 1);
        check("inh_no_sent", sent_count, s0);
        check("inh_dat_released", ps2_dat, 1'b1);
        check("inh_head_kept", fifo_count, 1);
        host_clk_low = 1'b0;
        wait_sent("inh_resent", 400);
        check_frame("inh_retry");
        check("inh_single_sent", sent_count, s0 + 1);
        check("inh_abort_total", abort_count, a0 + 1);
        step(1);
        wait_idle("inh_idle");

        // Inhibit during the stop bit is ignored.
        write_byte(8'($urandom_range(0, 255)), 1'b0);
        wait_bits("stop_bit10", 10);
        s0 = sent_count;
        a0 = abort_count;
        host_clk_low = 1'b1;
        step(20);
        host_clk_low = 1'b0;
        check("stop_sent", sent_count, s0 + 1);
        check("stop_no_abort", abort_count, a0);
        if (rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            void'(rx_len_q.pop_front());
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        step(3);
        check("stop_popped", fifo_count, 0);
        wait_idle("stop_idle");

        // Random bytes, random spacing; FIFO may fill and refuse.
        for (int i = 0; i < 14; i++) begin
            write_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            step($urandom_range(0, 30));
        end
        k = 0;
        while (sent_count < pushed && k < 20000) begin
            step(1);
            k++;
        end
        check("rand_drain", sent_count, pushed);
        while (rx_q.size() > 0 && exp_q.size() > 0) check_frame("rand");
        check("rand_no_abort", abort_count, a0);
        wait_idle("rand_idle");

        // Reset in the middle of bit 6 with three bytes queued.
        write_byte(8'hA5, 1'b0);
        write_byte(8'h3C, 1'b1);
        write_byte(8'h7E, 1'b0);
        wait_bits("rst_bit6", 6);
        step(2);
        s0 = sent_count;
        a0 = abort_count;
        reset = 1'b1;
        step(1);
        check("mrst_clk", ps2_clk, 1'b1);
        check("mrst_dat", ps2_dat, 1'b1);
        check("mrst_count", fifo_count, 0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ready", wr_ready, 1'b1);
        reset = 1'b0;
        exp_q.delete();
        pushed = sent_count;
        step(150);
        check("mrst_no_sent", sent_count, s0);
        check("mrst_no_abort", abort_count, a0);
        check("mrst_idle_clk", ps2_clk, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
